// File: rtl/cpu_pkg.sv
// Shared encodings for the cpu_param core: FSM states, instruction fields
// and a decoder that maps a 16-bit instruction word onto an instruction class.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_RST, S_IF1, S_IF2, S_DEC, S_EXEC, S_MEM, S_MEMW, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_MOVI, C_MOVR, C_ADD, C_CMP, C_AND, C_MVN, C_LDR, C_STR, C_BR, C_HALT
  } iclass_t;

  localparam logic [2:0] OPC_BR   = 3'b001;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  // Anything not explicitly recognised decodes as HALT.
  function automatic iclass_t decode(input logic [15:0] ir);
    iclass_t cls;
    cls = C_HALT;
    case (ir[15:13])
      OPC_MOV: begin
        if (ir[12:11] == OP_MOVI)      cls = C_MOVI;
        else if (ir[12:11] == OP_MOVR) cls = C_MOVR;
      end
      OPC_ALU: begin
        case (ir[12:11])
          OP_ADD:  cls = C_ADD;
          OP_CMP:  cls = C_CMP;
          OP_AND:  cls = C_AND;
          default: cls = C_MVN;
        endcase
      end
      OPC_LDR: if (ir[12:11] == OP_NONE) cls = C_LDR;
      OPC_STR: if (ir[12:11] == OP_NONE) cls = C_STR;
      OPC_BR:  if (ir[12:11] == OP_NONE && ir[10:8] <= COND_LE) cls = C_BR;
      default: cls = C_HALT;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/regfile.sv
// Eight-entry register file: two combinational read ports, one write port,
// all entries cleared by synchronous reset.
module regfile #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [2:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_reg
      logic [DATA_W-1:0] q_reg;
      always_ff @(posedge clk) begin
        if (rst)
          q_reg <= '0;
        else if (we && waddr == 3'(gi))
          q_reg <= wdata;
      end
      assign regs[gi] = q_reg;
    end
  endgenerate

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/cpu_param.sv
// Multi-cycle 16-bit-instruction CPU with a parameterised datapath and a
// single shared memory port used for fetch, load and store.
module cpu_param
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] start_pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out,
  output logic              halted,
  output logic [2:0]        flags
);

  state_t            state_reg, state_next;
  iclass_t           cls;
  logic [ADDR_W-1:0] pc_reg, addr_reg;
  logic [15:0]       ir_reg;
  logic [DATA_W-1:0] a_reg, b_reg, res_reg, wdata_reg, out_reg;
  logic [2:0]        flags_reg;

  logic              rf_we;
  logic [2:0]        rf_waddr, rf_raddr_b;
  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;
  logic [DATA_W-1:0] sh_b, diff;
  logic              ovf, taken;
  logic [ADDR_W-1:0] pc_target, ea;

  assign cls = decode(ir_reg);

  // STR reads its data register (Rd) through port B instead of Rm.
  assign rf_raddr_b = (cls == C_STR) ? ir_reg[7:5] : ir_reg[2:0];
  assign rf_waddr   = (cls == C_MOVI) ? ir_reg[10:8] : ir_reg[7:5];

  regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (res_reg),
    .raddr_a (ir_reg[10:8]),
    .rdata_a (rf_rdata_a),
    .raddr_b (rf_raddr_b),
    .rdata_b (rf_rdata_b)
  );

  always_comb begin
    sh_b = b_reg;
    case (ir_reg[4:3])
      SH_LSL:  sh_b = {b_reg[DATA_W-2:0], 1'b0};
      SH_LSR:  sh_b = {1'b0, b_reg[DATA_W-1:1]};
      SH_ASR:  sh_b = {b_reg[DATA_W-1], b_reg[DATA_W-1:1]};
      default: sh_b = b_reg;
    endcase
  end

  assign diff = a_reg - sh_b;
  assign ovf  = (a_reg[DATA_W-1] != sh_b[DATA_W-1]) && (diff[DATA_W-1] != a_reg[DATA_W-1]);
  assign ea        = a_reg[ADDR_W-1:0] + ADDR_W'($signed(ir_reg[4:0]));
  assign pc_target = pc_reg + ADDR_W'($signed(ir_reg[7:0]));

  // flags_reg holds {N,V,Z}.
  always_comb begin
    taken = 1'b0;
    case (ir_reg[10:8])
      COND_AL: taken = 1'b1;
      COND_EQ: taken = flags_reg[0];
      COND_NE: taken = !flags_reg[0];
      COND_LT: taken = flags_reg[2] ^ flags_reg[1];
      COND_LE: taken = (flags_reg[2] ^ flags_reg[1]) | flags_reg[0];
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_RST;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    rf_we      = 1'b0;
    case (state_reg)
      S_RST: state_next = S_IF1;
      S_IF1: begin
        mem_rd     = !rst;
        state_next = S_IF2;
      end
      S_IF2: state_next = S_DEC;
      S_DEC: begin
        case (cls)
          C_MOVI:  state_next = S_WB;
          C_BR:    state_next = S_IF1;
          C_HALT:  state_next = S_HALT;
          default: state_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls)
          C_CMP:        state_next = S_IF1;
          C_LDR, C_STR: state_next = S_MEM;
          default:      state_next = S_WB;
        endcase
      end
      S_MEM: begin
        // Strobes are gated by rst so an aborted access never reaches memory.
        mem_rd     = !rst && (cls == C_LDR);
        mem_wr     = !rst && (cls == C_STR);
        state_next = (cls == C_LDR) ? S_MEMW : S_IF1;
      end
      S_MEMW: state_next = S_WB;
      S_WB: begin
        rf_we      = cls inside {C_MOVI, C_MOVR, C_ADD, C_AND, C_MVN, C_LDR};
        state_next = S_IF1;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= start_pc;
      ir_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      wdata_reg <= '0;
      addr_reg  <= '0;
      out_reg   <= '0;
      flags_reg <= '0;
    end else begin
      case (state_reg)
        S_IF2: begin
          ir_reg <= mem_rdata[15:0];
          pc_reg <= pc_reg + ADDR_W'(1);
        end
        S_DEC: begin
          a_reg <= rf_rdata_a;
          b_reg <= rf_rdata_b;
          if (cls == C_MOVI) res_reg <= DATA_W'($signed(ir_reg[7:0]));
          if (cls == C_BR && taken) pc_reg <= pc_target;
        end
        S_EXEC: begin
          case (cls)
            C_MOVR: res_reg <= sh_b;
            C_ADD:  res_reg <= a_reg + sh_b;
            C_AND:  res_reg <= a_reg & sh_b;
            C_MVN:  res_reg <= ~sh_b;
            C_CMP:  flags_reg <= {diff[DATA_W-1], ovf, (diff == '0)};
            C_LDR, C_STR: begin
              addr_reg  <= ea;
              wdata_reg <= b_reg;
            end
            default: ;
          endcase
        end
        S_MEMW: res_reg <= mem_rdata;
        S_WB: begin
          if (cls inside {C_MOVR, C_ADD, C_AND, C_MVN}) out_reg <= res_reg;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = (state_reg == S_MEM) ? addr_reg : pc_reg;
  assign mem_wdata = wdata_reg;
  assign out       = out_reg;
  assign flags     = flags_reg;
  assign halted    = (state_reg == S_HALT);

endmodule

// File: tb/tb_cpu_param.sv
// Bench for cpu_param: an instruction-level reference interpreter predicts
// fetch timing, out, flags and stores for directed and random programs.
module tb_cpu_param;

  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  start_pc;
  logic [7:0]  mem_addr;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_wdata, mem_rdata, out;
  logic        halted;
  logic [2:0]  flags;

  logic [7:0]  sp32;
  logic [7:0]  m32_addr;
  logic        m32_rd, m32_wr;
  logic [31:0] m32_wdata, m32_rdata, out32;
  logic        halted32;
  logic [2:0]  flags32;

  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  int          wr_count;
  logic [7:0]  last_wa;
  logic [15:0] last_wd;

  logic [15:0] m_regs [8];
  logic [7:0]  m_pc;
  logic [15:0] m_out;
  logic        m_n, m_v, m_z, m_halt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_param #(.DATA_W(16), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start_pc(start_pc), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .out(out), .halted(halted), .flags(flags)
  );

  cpu_param #(.DATA_W(32), .ADDR_W(8)) dut32 (
    .clk(clk), .rst(rst), .start_pc(sp32), .mem_addr(m32_addr),
    .mem_rd(m32_rd), .mem_wr(m32_wr), .mem_wdata(m32_wdata),
    .mem_rdata(m32_rdata), .out(out32), .halted(halted32), .flags(flags32)
  );

  function automatic logic [15:0] movi(input logic [2:0] rn, input logic [7:0] imm);
    return {3'b110, 2'b10, rn, imm};
  endfunction
  function automatic logic [15:0] movr(input logic [2:0] rd, input logic [2:0] rm, input logic [1:0] sh);
    return {3'b110, 2'b00, 3'b000, rd, sh, rm};
  endfunction
  function automatic logic [15:0] alu(input logic [1:0] op, input logic [2:0] rd,
                                      input logic [2:0] rn, input logic [2:0] rm, input logic [1:0] sh);
    return {3'b101, op, rn, rd, sh, rm};
  endfunction
  function automatic logic [15:0] ldst(input logic [2:0] opc, input logic [2:0] rd,
                                       input logic [2:0] rn, input logic [4:0] imm);
    return {opc, 2'b00, rn, rd, imm};
  endfunction
  function automatic logic [15:0] br(input logic [2:0] cond, input logic [7:0] imm);
    return {3'b001, 2'b00, cond, imm};
  endfunction
  localparam logic [15:0] HALT_W = 16'hE000;

  // The 32-bit instance always runs MOV R3,#30 ; MVN R4,R3 ; HALT from address 0.
  function automatic logic [31:0] rom32(input logic [7:0] a);
    case (a)
      8'd0:    return {16'h0, movi(3'd3, 8'd30)};
      8'd1:    return {16'h0, alu(2'b11, 3'd4, 3'd0, 3'd3, 2'b00)};
      default: return {16'h0, HALT_W};
    endcase
  endfunction

  assign sp32 = 8'd0;

  always @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
      last_wa       <= mem_addr;
      last_wd       <= mem_wdata;
    end
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (m32_rd) m32_rdata <= rom32(m32_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Instruction-level interpreter: executes one instruction on the model state.
  task automatic model_step(output int cyc, output bit wr, output logic [7:0] wa, output logic [15:0] wd);
    logic [15:0] ir, x, y, a, res;
    logic [2:0]  opc, rn, rd, rm;
    logic [1:0]  op, shc;
    logic [7:0]  ea;
    int          sa, sb, d;
    bit          taken;
    ir  = ref_mem[m_pc];
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; shc = ir[4:3]; rm = ir[2:0];
    x = m_regs[rm];
    a = m_regs[rn];
    case (shc)
      2'd0:    y = x;
      2'd1:    y = x * 2;
      2'd2:    y = x / 2;
      default: y = x / 2 + (x[15] ? 16'h8000 : 16'h0000);
    endcase
    ea   = 8'(a + 16'($signed(ir[4:0])));
    m_pc = m_pc + 8'd1;
    wr = 1'b0; wa = '0; wd = '0; cyc = 3;
    if (opc == 3'd6 && op == 2'd2) begin
      m_regs[rn] = 16'($signed(ir[7:0]));
      cyc = 4;
    end else if (opc == 3'd6 && op == 2'd0) begin
      m_regs[rd] = y; m_out = y; cyc = 5;
    end else if (opc == 3'd5) begin
      cyc = 5;
      case (op)
        2'd0:    res = a + y;
        2'd2:    res = a & y;
        2'd3:    res = ~y;
        default: res = '0;
      endcase
      if (op == 2'd1) begin
        sa = int'($signed(a)); sb = int'($signed(y)); d = sa - sb;
        res = 16'(d);
        m_n = res[15]; m_z = (res == 16'd0); m_v = (d > 32767) || (d < -32768);
        cyc = 4;
      end else begin
        m_regs[rd] = res; m_out = res;
      end
    end else if (opc == 3'd3 && op == 2'd0) begin
      m_regs[rd] = ref_mem[ea]; cyc = 7;
    end else if (opc == 3'd4 && op == 2'd0) begin
      ref_mem[ea] = m_regs[rd]; wr = 1'b1; wa = ea; wd = m_regs[rd]; cyc = 5;
    end else if (opc == 3'd1 && op == 2'd0 && rn <= 3'd4) begin
      taken = (rn == 3'd0) || (rn == 3'd1 && m_z) || (rn == 3'd2 && !m_z) ||
              (rn == 3'd3 && m_n != m_v) || (rn == 3'd4 && (m_n != m_v || m_z));
      if (taken) m_pc = m_pc + ir[7:0];
    end else begin
      m_halt = 1'b1;
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [2:0] r1, r2, r3;
    r1 = 3'($urandom_range(0, 7)); r2 = 3'($urandom_range(0, 7)); r3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 19))
      0, 1, 2, 18, 19: return movi(r1, 8'($urandom));
      3:               return movr(r1, r2, 2'($urandom));
      4, 5:            return alu(2'd0, r1, r2, r3, 2'($urandom));
      6, 7:            return alu(2'd1, r1, r2, r3, 2'($urandom));
      8:               return alu(2'd2, r1, r2, r3, 2'($urandom));
      9:               return alu(2'd3, r1, r2, r3, 2'($urandom));
      10, 11:          return ldst(3'b011, r1, r2, 5'($urandom));
      12, 13:          return ldst(3'b100, r1, r2, 5'($urandom));
      14, 15, 16:      return br(3'($urandom_range(0, 4)), 8'($urandom_range(0, 12) - 4));
      default:         return 16'($urandom);
    endcase
  endfunction

  task automatic fill_halt();
    for (int a = 0; a < 256; a++) ref_mem[a] = HALT_W;
  endtask

  task automatic load_mem();
    rst     = 1'b1;
    load_en = 1'b1;
    for (int a = 0; a < 256; a++) begin
      load_addr = 8'(a);
      load_data = ref_mem[a];
      @(negedge clk);
    end
    load_en = 1'b0;
  endtask

  // Leaves the DUT sampled in its first IF1 cycle.
  task automatic do_reset(input logic [7:0] s);
    rst      = 1'b1;
    start_pc = s;
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_strobes", 32'({mem_rd, mem_wr}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 8; r++) m_regs[r] = '0;
    m_pc = s; m_out = '0; m_n = 0; m_v = 0; m_z = 0; m_halt = 0;
  endtask

  task automatic run_prog(input string name, input int max_instr);
    int          cyc, w0, nbad;
    bit          wr;
    logic [7:0]  wa, pc0;
    logic [15:0] wd;
    for (int i = 0; i < max_instr && !m_halt; i++) begin
      pc0 = m_pc;
      check({name, "_fetch_rd"}, 32'({mem_rd, mem_wr}), 32'd2);
      check({name, "_fetch_addr"}, 32'(mem_addr), 32'(m_pc));
      w0 = wr_count;
      model_step(cyc, wr, wa, wd);
      repeat (cyc) @(negedge clk);
      check({name, "_halted"}, 32'(halted), 32'(m_halt));
      check({name, "_out"}, 32'(out), 32'(m_out));
      check({name, "_flags"}, 32'(flags), 32'({m_n, m_v, m_z}));
      check({name, "_writes"}, 32'(wr_count - w0), wr ? 32'd1 : 32'd0);
      if (wr) begin
        check({name, "_waddr"}, 32'(last_wa), 32'(wa));
        check({name, "_wdata"}, 32'(last_wd), 32'(wd));
      end
      $display("[%s] pc=%02h ir=%04h cycles=%0d out=%04h flags=%03b halted=%0b",
               name, pc0, ref_mem[pc0], cyc, out, flags, halted);
    end
    if (m_halt) begin
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        check({name, "_halt_strobes"}, 32'({mem_rd, mem_wr}), 32'd0);
        check({name, "_halt_out"}, 32'(out), 32'(m_out));
        check({name, "_halt_flag"}, 32'(halted), 32'd1);
      end
      $display("[%s] held in HALT for 50 cycles", name);
    end
    nbad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) nbad++;
    check({name, "_mem_image"}, 32'(nbad), 32'd0);
  endtask

  initial begin
    int w0;
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start_pc = '0; wr_count = 0; last_wa = '0; last_wd = '0;

    // MOV R0,#7 ; MOV R1,#2 ; ADD R2,R0,R1 LSL1 : out stays 0, then 11 after
    // the 13 cycles counted from the first fetch.
    fill_halt();
    ref_mem[0] = movi(3'd0, 8'd7);
    ref_mem[1] = movi(3'd1, 8'd2);
    ref_mem[2] = alu(2'd0, 3'd2, 3'd0, 3'd1, 2'd1);
    load_mem();
    do_reset(8'd0);
    run_prog("add", 10);
    check("add_out11", 32'(out), 32'd11);

    // MOV R3,#30 ; MVN R4,R3 on both widths.
    fill_halt();
    ref_mem[0] = movi(3'd3, 8'd30);
    ref_mem[1] = alu(2'd3, 3'd4, 3'd0, 3'd3, 2'd0);
    load_mem();
    do_reset(8'd0);
    run_prog("mvn", 10);
    check("mvn_out16", 32'(out), 32'h0000FFE1);
    check("mvn_out32", out32, 32'hFFFFFFE1);

    // CMP 2-3 then BLT +2 lands three words past the branch.
    fill_halt();
    ref_mem[0] = movi(3'd0, 8'd2);
    ref_mem[1] = movi(3'd1, 8'd3);
    ref_mem[2] = alu(2'd1, 3'd0, 3'd0, 3'd1, 2'd0);
    ref_mem[3] = br(3'd3, 8'd2);
    ref_mem[4] = movr(3'd6, 3'd0, 2'd0);
    ref_mem[5] = movr(3'd6, 3'd1, 2'd0);
    load_mem();
    do_reset(8'd0);
    run_prog("blt", 10);
    check("blt_flags", 32'(flags), 32'b100);
    check("blt_out", 32'(out), 32'd0);

    // Build R0=0x1234, STR R0,[R1,#1] ; LDR R5,[R1,#1] ; MVN R6,R5 exposes R5.
    fill_halt();
    ref_mem[8'h40] = movi(3'd0, 8'h12);
    for (int k = 1; k <= 8; k++) ref_mem[8'h40 + k] = alu(2'd0, 3'd0, 3'd0, 3'd0, 2'd0);
    ref_mem[8'h49] = movi(3'd7, 8'h34);
    ref_mem[8'h4A] = alu(2'd0, 3'd0, 3'd0, 3'd7, 2'd0);
    ref_mem[8'h4B] = movi(3'd1, 8'd4);
    ref_mem[8'h4C] = ldst(3'b100, 3'd0, 3'd1, 5'd1);
    ref_mem[8'h4D] = ldst(3'b011, 3'd5, 3'd1, 5'd1);
    ref_mem[8'h4E] = alu(2'd3, 3'd6, 3'd0, 3'd5, 2'd0);
    load_mem();
    do_reset(8'h40);
    w0 = wr_count;
    run_prog("ldst", 20);
    check("ldst_one_write", 32'(wr_count - w0), 32'd1);
    check("ldst_mem5", 32'(mem[5]), 32'h1234);
    check("ldst_r5", 32'(out), 32'h0000EDCB);

    // HALT at 250, then a fresh reset fetches from start_pc again.
    fill_halt();
    load_mem();
    do_reset(8'd250);
    run_prog("halt", 5);
    do_reset(8'd250);
    check("halt_refetch", 32'({mem_rd, mem_addr}), 32'h1FA);

    // PC wraps from 255 to 0.
    fill_halt();
    ref_mem[255] = movi(3'd2, 8'd5);
    ref_mem[0]   = movi(3'd3, 8'd6);
    load_mem();
    do_reset(8'd255);
    run_prog("wrap", 5);

    // Reset during MEM of a STR must suppress the write.
    fill_halt();
    ref_mem[8'h10] = ldst(3'b100, 3'd0, 3'd1, 5'd1);
    load_mem();
    do_reset(8'h10);
    repeat (4) @(negedge clk);
    check("abort_strobe_before", 32'(mem_wr), 32'd1);
    w0  = wr_count;
    rst = 1'b1;
    @(negedge clk);
    check("abort_no_write", 32'(wr_count - w0), 32'd0);
    check("abort_strobe_after", 32'(mem_wr), 32'd0);
    $display("[abort] reset in MEM of STR, writes=%0d", wr_count - w0);

    // Random programs from random start addresses.
    for (int t = 0; t < 4; t++) begin
      for (int a = 0; a < 256; a++) ref_mem[a] = rand_instr();
      load_mem();
      do_reset(8'($urandom_range(0, 255)));
      run_prog("rand", 40);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
